// File: rtl/md_if.sv
// Handshake and result bundle between the execute stage and the multiply/divide unit.
// The pipeline drives through the master modport; md_unit is the slave.
interface md_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mthi;
  logic             mtlo;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, mthi, mtlo,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, mthi, mtlo,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO. Operands are latched at start and
// the result is formed from the latched values and HI/LO, then committed when the count expires.
module md_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic  clk,
  input logic  reset,
  md_if.slave  bus
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int W2   = 2 * WIDTH;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             busy_q;
  logic             done_q;

  logic             is_div_q;
  logic             start_is_div;
  logic [W2-1:0]    a_ext;
  logic [W2-1:0]    b_ext;
  logic [W2-1:0]    prod;
  logic [W2-1:0]    acc;
  logic [W2-1:0]    mac;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] den;
  logic [WIDTH-1:0] uq;
  logic [WIDTH-1:0] ur;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] hi_d;
  logic [WIDTH-1:0] lo_d;

  // op[0] selects unsigned; op[2] selects accumulate, op[1] then selects subtract
  assign is_div_q     = (op_q[2:1] == 2'b01);
  assign start_is_div = (bus.op[2:1] == 2'b01);

  assign a_ext = op_q[0] ? {{WIDTH{1'b0}}, a_q} : {{WIDTH{a_q[WIDTH-1]}}, a_q};
  assign b_ext = op_q[0] ? {{WIDTH{1'b0}}, b_q} : {{WIDTH{b_q[WIDTH-1]}}, b_q};
  assign prod  = a_ext * b_ext;
  assign acc   = {hi_q, lo_q};
  assign mac   = op_q[1] ? (acc - prod) : (acc + prod);

  // Sign-magnitude division; most-negative / -1 falls out as quotient 0x80..0, remainder 0
  assign a_neg = ~op_q[0] & a_q[WIDTH-1];
  assign b_neg = ~op_q[0] & b_q[WIDTH-1];
  assign a_mag = a_neg ? (~a_q + 1'b1) : a_q;
  assign b_mag = b_neg ? (~b_q + 1'b1) : b_q;
  assign den   = (b_q == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
  assign uq    = a_mag / den;
  assign ur    = a_mag % den;
  assign quo   = (a_neg ^ b_neg) ? (~uq + 1'b1) : uq;
  assign rem   = a_neg ? (~ur + 1'b1) : ur;

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (is_div_q) begin
      if (b_q == '0) begin
        hi_d = a_q;
        lo_d = '1;
      end else begin
        hi_d = rem;
        lo_d = quo;
      end
    end else if (op_q[2]) begin
      {hi_d, lo_d} = mac;
    end else begin
      {hi_d, lo_d} = prod;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            op_q    <= bus.op;
            a_q     <= bus.a;
            b_q     <= bus.b;
            cnt_q   <= start_is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            if (bus.mthi) hi_q <= bus.a;
            if (bus.mtlo) lo_q <= bus.a;
          end
        end
        RUN: begin
          if (cnt_q == CW'(1)) begin
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_md_unit.sv
// Directed plus randomized checks of md_unit against an arithmetic reference model of HI/LO.
module tb_md_unit;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  md_if #(.WIDTH(32)) bus ();

  md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int compared   = 0;
  int mismatched = 0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: {HI,LO} after an op, from plain integer arithmetic
  function automatic logic [63:0] ref_op(input logic [2:0] o, input logic [31:0] x,
                                         input logic [31:0] y, input logic [31:0] h,
                                         input logic [31:0] l);
    logic [63:0] acc;
    logic [63:0] p;
    int          sx;
    int          sy;
    acc = {h, l};
    sx  = x;
    sy  = y;
    if (o[0]) p = {32'd0, x} * {32'd0, y};
    else      p = 64'(longint'(sx) * longint'(sy));
    case (o)
      3'd0, 3'd1: return p;
      3'd4, 3'd5: return acc + p;
      3'd6, 3'd7: return acc - p;
      3'd2: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        return {32'(sx % sy), 32'(sx / sy)};
      end
      default: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  // Called at a negedge with the unit idle; returns at the negedge of the cycle busy falls
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit inj, input bit with_mtlo, input string tag);
    int          n;
    logic [63:0] exp;
    n = (o == 3'd2 || o == 3'd3) ? 10 : 5;
    exp = ref_op(o, x, y, m_hi, m_lo);
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = x;
    bus.b     = y;
    bus.mtlo  = with_mtlo;
    @(negedge clk);
    bus.start = 1'b0;
    bus.mtlo  = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    for (int k = 0; k < n; k++) begin
      check({tag, " busy"}, 64'(bus.busy), 64'd1);
      check({tag, " hold"}, {bus.hi, bus.lo}, {m_hi, m_lo});
      if (k == 0) check({tag, " done_low"}, 64'(bus.done), 64'd0);
      if (inj && k == 1) begin
        bus.start = 1'b1; bus.op = 3'd0; bus.a = 32'd9; bus.b = 32'd9;
      end
      if (inj && k == 2) begin
        bus.start = 1'b0; bus.mthi = 1'b1; bus.a = 32'h1234;
      end
      if (inj && k == 3) bus.mthi = 1'b0;
      @(negedge clk);
    end
    check({tag, " busy_fall"}, 64'(bus.busy), 64'd0);
    check({tag, " done"}, 64'(bus.done), 64'd1);
    check({tag, " result"}, {bus.hi, bus.lo}, exp);
    {m_hi, m_lo} = exp;
    $display("op=%0d a=%08h b=%08h -> hi=%08h lo=%08h", o, x, y, bus.hi, bus.lo);
  endtask

  task automatic mt(input bit h, input bit l, input logic [31:0] v);
    bus.mthi = h;
    bus.mtlo = l;
    bus.a    = v;
    @(negedge clk);
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;
    if (h) m_hi = v;
    if (l) m_lo = v;
    check("mt hilo", {bus.hi, bus.lo}, {m_hi, m_lo});
    check("mt busy", 64'(bus.busy), 64'd0);
    check("mt done", 64'(bus.done), 64'd0);
    $display("mt hi=%0b lo=%0b a=%08h -> hi=%08h lo=%08h", h, l, v, bus.hi, bus.lo);
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] rx;
    logic [31:0] ry;
    reset = 1'b0;
    bus.start = 1'b0; bus.op = 3'd0; bus.a = '0; bus.b = '0;
    bus.mthi = 1'b0; bus.mtlo = 1'b0;
    m_hi = '0; m_lo = '0;
    #1;
    check("reset state", {31'd0, bus.busy, bus.done, bus.hi[0], bus.hi, bus.lo[31:1]}, 64'd0);
    check("reset hilo", {bus.hi, bus.lo}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    run_op(3'd0, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0, "mult");
    check("mult const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    @(negedge clk);
    check("done pulse end", 64'(bus.done), 64'd0);
    run_op(3'd1, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0, "multu");
    check("multu const", {bus.hi, bus.lo}, 64'h0000_0006_FFFF_FFEB);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, "div");
    check("div const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(3'd3, 32'd7, 32'd0, 1'b0, 1'b0, "divu0");
    check("divu0 const", {bus.hi, bus.lo}, 64'h0000_0007_FFFF_FFFF);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, "divovf");
    check("divovf const", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);

    mt(1'b1, 1'b0, 32'd0);
    mt(1'b0, 1'b1, 32'hFFFF_FFFF);
    run_op(3'd5, 32'd1, 32'd1, 1'b0, 1'b0, "maddu");
    check("maddu const", {bus.hi, bus.lo}, 64'h0000_0001_0000_0000);
    run_op(3'd6, 32'd1, 32'd1, 1'b0, 1'b0, "msub b2b");
    check("msub const", {bus.hi, bus.lo}, 64'h0000_0000_FFFF_FFFF);

    run_op(3'd0, 32'd6, 32'd7, 1'b1, 1'b0, "ignored");
    check("ignored const", {bus.hi, bus.lo}, 64'd42);

    mt(1'b1, 1'b1, 32'd5);
    run_op(3'd5, 32'd2, 32'd3, 1'b0, 1'b1, "start+mtlo");
    check("start+mtlo const", {bus.hi, bus.lo}, 64'h0000_0005_0000_000B);

    // Asynchronous reset in the fourth busy cycle of a divide
    mt(1'b1, 1'b1, 32'hA5A5_0F0F);
    bus.start = 1'b1; bus.op = 3'd2; bus.a = 32'd100; bus.b = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre-reset busy", 64'(bus.busy), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("async busy", 64'(bus.busy), 64'd0);
    check("async hilo", {bus.hi, bus.lo}, 64'd0);
    check("async done", 64'(bus.done), 64'd0);
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    reset = 1'b1;
    run_op(3'd0, 32'd2, 32'd3, 1'b0, 1'b0, "post-reset");
    check("post-reset const", {bus.hi, bus.lo}, 64'd6);

    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      rx = $urandom;
      case ($urandom_range(0, 7))
        0:       ry = 32'd0;
        1:       ry = 32'($urandom_range(1, 15));
        2:       ry = 32'hFFFF_FFFF;
        default: ry = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) rx = 32'h8000_0000;
      if ($urandom_range(0, 3) == 0) mt(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
      run_op(ro, rx, ry, 1'b0, 1'b0, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/md_unit.md
# md_unit

Parametrised multiply/divide unit for the execute stage of the pipelined MIPS core. It holds the HI/LO register pair and runs signed/unsigned multiply, multiply-accumulate/subtract and divide over a fixed, parameter-set number of cycles. While an operation runs it asserts `busy`, which the hazard unit uses to stall HI/LO consumers in D.

## Interface
- `WIDTH`, 32: operand and HI/LO width.
- `MULT_CYCLES`, 5: busy cycles for multiply and multiply-accumulate ops; must be ≥1.
- `DIV_CYCLES`, 10: busy cycles for divide ops; must be ≥1.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  launch the operation selected by `op`, using `a` and `b`.
- `op`  in  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MADDU, 110 MSUB, 111 MSUBU.
- `a`  in  WIDTH  rs operand, already forwarded.
- `b`  in  WIDTH  rt operand, already forwarded.
- `mthi`  in  1  write `a` to HI.
- `mtlo`  in  1  write `a` to LO.
- `busy`  out  1  operation in flight.
- `done`  out  1  one-cycle pulse in the cycle HI/LO first show a committed result.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- Two states: IDLE and RUN, with a down-counter sized to hold max(MULT_CYCLES, DIV_CYCLES).
- IDLE, `start`=1 at an edge:
  - Latch `op`, `a` and `b`.
  - Load the counter with MULT_CYCLES or DIV_CYCLES.
  - Go to RUN.
- RUN: the counter decrements each edge. At the edge where it reaches zero:
  - Commit the result to HI/LO.
  - Return to IDLE.
- `start`, `mthi` and `mtlo` are ignored while `busy`=1. The hazard unit must stall; the unit does not queue.
- In IDLE, `mthi`/`mtlo` write `a` at the next edge. Both may be asserted together; then HI=LO=`a`.
- Simultaneous `start` and `mthi`/`mtlo` in IDLE: `start` wins and the MT writes are dropped.
- MULT/MULTU: {HI,LO} = 2·WIDTH-bit signed/unsigned product.
- MADD(U): {HI,LO} = {HI,LO} + product. MSUB(U): {HI,LO} = {HI,LO} − product.
  - Arithmetic is modulo 2^(2·WIDTH).
  - The accumulator is the HI/LO value at commit, which equals the value at start because HI/LO cannot change while busy.
- DIV/DIVU: LO = quotient, HI = remainder.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - Signed overflow (most-negative / −1): LO = most-negative, HI = 0.
  - Divide by zero (both signednesses): LO = all ones, HI = `a`.
- The result may be computed at start or iteratively, provided it is visible exactly at commit and not earlier. `hi`/`lo` keep their old values throughout RUN.

## Timing
- Reset asserted (low): immediately, without waiting for a clock:
  - `busy`=0, `done`=0, `hi`=0, `lo`=0, counter=0, state IDLE.
  - Any in-flight operation is discarded.
- Reset deassertion takes effect at the next edge; the first `start` can be accepted at that edge.
- Latency: `start` is sampled at edge t.
  - `busy`=1 in cycles t+1 through t+N, where N is the op's cycle count.
  - At edge t+N: `busy` falls, `hi`/`lo` take the result, and `done`=1 for cycle t+N+1 only.
- Back-to-back: `start` may be asserted in the cycle `busy` falls (cycle t+N+1), so no dead cycle is required. An accumulate op issued there sees the just-committed HI/LO.
- `mthi`/`mtlo` latency: one edge; `busy` and `done` are unaffected.
- `busy` and `done` are registered outputs; they do not depend combinationally on inputs.

## Test plan
Parameters: WIDTH=32, MULT_CYCLES=5, DIV_CYCLES=10.
- Reset low mid-DIV (cycle 4 of busy) → `busy`, `hi`, `lo` read 0 immediately, before the next edge; after release, MULT 2×3 gives lo=6, hi=0 after 5 busy cycles.
- MULT a=0xFFFFFFFD, b=7 → `busy` high exactly cycles 1–5, then hi=0xFFFFFFFF, lo=0xFFFFFFEB, `done` pulse for 1 cycle; MULTU with same operands → hi=0x00000006, lo=0xFFFFFFEB.
- DIV a=0xFFFFFFF9 (−7), b=2 → after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7, b=0 → lo=0xFFFFFFFF, hi=7; DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- MTHI a=0, MTLO a=0xFFFFFFFF, then MADDU 1×1 → hi=1, lo=0; then MSUB 1×1 issued in the cycle `busy` falls → hi=0, lo=0xFFFFFFFF.
- During busy, pulse `start` (MULT 9×9) and `mthi` (a=0x1234) → both ignored; final HI/LO equal the original op's result, and `busy` length is unchanged.
- `start`+`mtlo` in the same IDLE cycle → MT dropped; LO ends up equal to the op result.
